beep_detector: RTL

- Receive-side counterpart of the tone generator: samples a 1-bit square-wave input and decides whether it carries a tone of TONE_HZ for at least the configured duration.
- Runs on the divided sampling clock clkout, on the line-input path of the answering machine.
- Asserts a level flag plus one-cycle start and end pulses. The channel controller uses these to recognise the caller-side beep.

---
 rtl/beep_detector_if.sv | 20 ++
 rtl/beep_detector.sv | 102 ++++++++++
 2 files changed

// File: rtl/beep_detector_if.sv
// beep_detector_if: control, tone input and detection results of the beep detector
interface beep_detector_if #(
  parameter int CW = 16
);
  logic          enable;
  logic          tone_in;
  logic          detected;
  logic          det_pulse;
  logic          end_pulse;
  logic [19:0]   half_count;
  logic [CW-1:0] last_half;
  modport master (
    output enable, tone_in,
    input  detected, det_pulse, end_pulse, half_count, last_half
  );
  modport slave (
    input  enable, tone_in,
    output detected, det_pulse, end_pulse, half_count, last_half
  );
endinterface

// File: rtl/beep_detector.sv
// beep_detector: qualifies a square-wave tone by measuring consecutive half-periods
module beep_detector #(
  parameter int SAMPLE_HZ = 1000,
  parameter int TONE_HZ   = 50,
  parameter int TOL       = 1,
  parameter int T_SEC     = 1,
  parameter int CW        = 16
) (
  input  logic              clkout,
  input  logic              rst_n,
  beep_detector_if.slave    bus
);
  localparam int HALF_NOM   = SAMPLE_HZ / (2 * TONE_HZ);
  localparam int MIN_HALVES = 2 * T_SEC * TONE_HZ;
  localparam logic [CW:0]   NOM  = (CW+1)'(HALF_NOM);
  localparam logic [CW:0]   TOLV = (CW+1)'(TOL);
  localparam logic [CW-1:0] TMAX = CW'(HALF_NOM + TOL);
  localparam logic [19:0]   MINH = 20'(MIN_HALVES);
  typedef enum logic [1:0] {IDLE, TRACK, DETECTED} state_t;
  state_t        state, state_n;
  logic          s1, s2, s3;
  logic [CW-1:0] run, last;
  logic [19:0]   hc, hc_n, hc_inc;
  logic [CW:0]   l_ext, diff;
  logic          tone_edge, valid, timeout, det_p, end_p, det_q, end_q;
  assign tone_edge = s2 ^ s3;
  assign l_ext     = {1'b0, run};
  assign diff      = l_ext > NOM ? l_ext - NOM : NOM - l_ext;
  assign valid     = diff <= TOLV;
  assign timeout   = !tone_edge && run > TMAX;
  assign hc_inc    = &hc ? hc : hc + 20'd1;
  // synchronise the tone line and measure the sample run between edges
  always_ff @(posedge clkout or negedge rst_n)
    if (!rst_n) begin
      {s3, s2, s1} <= '0;
      run          <= '0;
      last         <= '0;
    end else begin
      {s3, s2, s1} <= {s2, s1, bus.tone_in};
      if (tone_edge) last <= run;
      run <= !bus.enable ? '0 : tone_edge ? CW'(1) : &run ? run : run + CW'(1);
    end
  // state, run-length count and registered event pulses
  always_ff @(posedge clkout or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      hc    <= '0;
      det_q <= 1'b0;
      end_q <= 1'b0;
    end else begin
      state <= state_n;
      hc    <= hc_n;
      det_q <= det_p;
      end_q <= end_p;
    end
  // next state: enable low overrides any edge seen in the same cycle
  always_comb begin
    state_n = state;
    hc_n    = hc;
    det_p   = 1'b0;
    end_p   = 1'b0;
    if (!bus.enable) begin
      state_n = IDLE;
      hc_n    = '0;
      end_p   = state == DETECTED;
    end else
      case (state)
        IDLE:
          if (tone_edge) begin
            state_n = TRACK;
            hc_n    = '0;
          end
        TRACK:
          if (tone_edge && valid) begin
            hc_n = hc_inc;
            if (hc_inc == MINH) begin
              state_n = DETECTED;
              det_p   = 1'b1;
            end
          end else if (tone_edge)
            hc_n = '0;
          else if (timeout) begin
            state_n = IDLE;
            hc_n    = '0;
          end
        DETECTED:
          if (tone_edge && valid)
            hc_n = hc_inc;
          else if (tone_edge || timeout) begin
            state_n = IDLE;
            hc_n    = '0;
            end_p   = 1'b1;
          end
        default: state_n = IDLE;
      endcase
  end
  assign bus.detected   = state == DETECTED;
  assign bus.det_pulse  = det_q;
  assign bus.end_pulse  = end_q;
  assign bus.half_count = hc;
  assign bus.last_half  = last;
endmodule
